mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester and its load/store requester.
- Sits between the core's instruction and data cache interfaces and a single memory/cache port.
- Grants one transaction at a time with round-robin tie-breaking and registered outbound request fields.
- A watchdog aborts transactions the memory never answers.

Parameters:
DATA_WIDTH, 32, address/data width
BYTE_DATA_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
TIMEOUT_CYCLES, 255, max cycles waiting for mem_valid; 0 disables watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
inst_req  in  1  fetch request, held until inst_valid
inst_addr  in  DATA_WIDTH  fetch address
inst_valid  out  1  one-cycle response strobe to fetch
inst_data  out  DATA_WIDTH  fetch read data
data_req  in  1  LSU request, held until data_valid
data_addr  in  DATA_WIDTH  LSU address
data_wdata  in  DATA_WIDTH  LSU store data
data_we  in  1  LSU write enable
data_be  in  BYTE_DATA_WIDTH  LSU byte enable
data_valid  out  1  one-cycle response strobe to LSU
data_rdata  out  DATA_WIDTH  LSU read data
mem_req  out  1  request to memory
mem_addr  out  DATA_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched store data
mem_we  out  1  latched write enable
mem_be  out  BYTE_DATA_WIDTH  latched byte enable
mem_valid  in  1  memory completion strobe
mem_rdata  in  DATA_WIDTH  memory read data
err  out  1  pulses with the valid strobe when a transaction timed out

Behaviour:
- Reset is asynchronous and active-low: rst=0 forces state IDLE immediately, without waiting for a clock edge.
- Reset values: mem_req=0; mem_addr, mem_wdata, mem_we, mem_be = 0; last_grant=INST; watchdog=0.
- Reset mid-transaction drops mem_req immediately. Any later mem_valid is ignored while in IDLE.
- States: IDLE, INST_BUSY, DATA_BUSY.
- IDLE, only inst_req=1: latch inst_addr, set mem_we=0 and mem_be=all ones, go to INST_BUSY.
- IDLE, only data_req=1: latch addr/wdata/we/be, go to DATA_BUSY.
- IDLE, both requesting: grant the requester that is not last_grant. Because last_grant resets to INST, data wins the first tie.
- On every grant, last_grant is updated to the winner.
- Latency: a request sampled in IDLE at edge N gives mem_req=1 from cycle N+1. Minimum turnaround is mem_valid in cycle N+1, so the response arrives 1 cycle after acceptance.
- BUSY states: mem_req=1 and the latched fields stay stable until completion. Requester inputs are ignored during BUSY.
- Completion, mem_valid=1 in BUSY:
  - The owner's *_valid=1 combinationally in the same cycle, with *_data/*_rdata = mem_rdata.
  - The non-owner's valid stays 0.
  - Next state is IDLE; mem_req=0 the following cycle.
- mem_valid while in IDLE is ignored (no valid strobes).
- Requester contract:
  - A requester deasserts req in the cycle after its valid.
  - If req is still high in that cycle, it is a new request and is arbitrated normally in IDLE.
  - Back-to-back throughput is therefore one transaction per 2 cycles minimum.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter clears on entering a BUSY state and increments each BUSY cycle without mem_valid.
  - When count == TIMEOUT_CYCLES-1 and mem_valid=0: pulse the owner's valid with data = 0 and err=1, then go to IDLE (abort).
  - If mem_valid and timeout coincide, mem_valid wins and err=0.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- TIMEOUT_CYCLES=0: no watchdog and err is tied to 0.
- err=0 in every other cycle.
- inst_data and data_rdata output mem_rdata when their valid=1 and 0 otherwise.

Decomposition:
- Shared package mem_arb_pkg holds the state encoding (IDLE/INST_BUSY/DATA_BUSY, 2 bits) and requester IDs (REQ_INST=0, REQ_DATA=1).
- One sub-module, mem_arb_watchdog, holds the counter, clear/enable inputs and a timeout output, parameterised by TIMEOUT_CYCLES.
- Arbitration and muxing stay in the top module.

Test Plan:
1. Reset, then inst_req=1 with inst_addr=0x100; memory answers 2 cycles later with rdata=0xDEADBEEF.
   -> mem_req=1 and mem_addr=0x100 one cycle after acceptance, mem_we=0, mem_be=0xF; inst_valid=1 for exactly 1 cycle with inst_data=0xDEADBEEF; data_valid stays 0.
2. inst_req and data_req asserted in the same cycle, both held.
   -> data is served first (last_grant=INST at reset), then inst; a third simultaneous pair goes to data again, showing strict alternation.
3. data_req store: addr=0x2004, wdata=0x12345678, we=1, be=0x3; inputs changed mid-transaction.
   -> mem_addr/mem_wdata/mem_we/mem_be hold 0x2004/0x12345678/1/0x3 stable until mem_valid.
4. TIMEOUT_CYCLES=8, memory never responds to inst_req.
   -> inst_valid=1, err=1 and inst_data=0 in BUSY cycle 8; mem_req=0 the next cycle; a following data_req is served normally.
5. rst pulled low asynchronously between clock edges while in DATA_BUSY.
   -> mem_req drops before the next edge; after rst=1, a late mem_valid produces no valid strobe.
6. LSU re-asserts data_req in the cycle after data_valid while inst_req is pending.
   -> round-robin grants inst next; the data request follows; no request is lost.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified memory-port arbiter: the arbiter state
// encoding, the requester identifiers used for round-robin bookkeeping and a
// small helper that tells whether a state owns the memory port.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INST_BUSY = 2'd1,
      DATA_BUSY = 2'd2
   } arb_state_e;

   localparam logic REQ_INST = 1'b0;
   localparam logic REQ_DATA = 1'b1;

   // True while a transaction owns the memory port.
   function automatic logic is_busy(input arb_state_e state);
      return (state == INST_BUSY) || (state == DATA_BUSY);
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
// Counts cycles a granted transaction has waited for the memory to answer.
//   clk, rst  : clock and asynchronous active-low reset
//   clr       : restart the count (asserted on the grant cycle)
//   en        : count this cycle (busy and no memory completion)
//   timeout   : high while the count has reached TIMEOUT_CYCLES-1
// With TIMEOUT_CYCLES = 0 the watchdog is absent and timeout is tied low.
// ---------------------------------------------------------------------------
module mem_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wd
         localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
         localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

         logic [CNT_W-1:0] count_r;

         // Wait counter: cleared on grant, advanced on each unanswered busy cycle.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               count_r <= {CNT_W{1'b0}};
            end else if (clr) begin
               count_r <= {CNT_W{1'b0}};
            end else if (en) begin
               count_r <= count_r + ONE;
            end else begin
               count_r <= count_r;
            end
         end

         // The owner gates this with its busy state, so a stale count in IDLE is harmless.
         assign timeout = (count_r == LIMIT);
      end else begin : g_no_wd
         assign timeout = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction-fetch and load/store
// requesters. One transaction at a time, round-robin on ties, outbound
// request fields latched at grant, watchdog abort of unanswered requests.
//   inst_req/inst_addr          -> fetch request; inst_valid/inst_data back
//   data_req/addr/wdata/we/be   -> LSU request; data_valid/data_rdata back
//   mem_req/addr/wdata/we/be    -> latched request to memory
//   mem_valid/mem_rdata         <- memory completion
//   err                         -> pulses with the valid strobe on a timeout
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_DATA_WIDTH = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inst_req,
   input  logic [DATA_WIDTH-1:0]      inst_addr,
   output logic                       inst_valid,
   output logic [DATA_WIDTH-1:0]      inst_data,
   input  logic                       data_req,
   input  logic [DATA_WIDTH-1:0]      data_addr,
   input  logic [DATA_WIDTH-1:0]      data_wdata,
   input  logic                       data_we,
   input  logic [BYTE_DATA_WIDTH-1:0] data_be,
   output logic                       data_valid,
   output logic [DATA_WIDTH-1:0]      data_rdata,
   output logic                       mem_req,
   output logic [DATA_WIDTH-1:0]      mem_addr,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   output logic                       mem_we,
   output logic [BYTE_DATA_WIDTH-1:0] mem_be,
   input  logic                       mem_valid,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic                       err
);

   arb_state_e                 state_r;
   arb_state_e                 state_nxt_s;
   logic                       last_grant_r;
   logic                       grant_s;
   logic                       grant_data_s;
   logic                       wd_timeout_s;
   logic                       wd_en_s;
   logic [DATA_WIDTH-1:0]      addr_r;
   logic [DATA_WIDTH-1:0]      wdata_r;
   logic                       we_r;
   logic [BYTE_DATA_WIDTH-1:0] be_r;

   assign wd_en_s = is_busy(state_r) && !mem_valid;

   mem_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (grant_s),
      .en      (wd_en_s),
      .timeout (wd_timeout_s)
   );

   // Arbitration, completion and abort decisions plus the response muxing.
   always_comb begin
      state_nxt_s  = state_r;
      grant_s      = 1'b0;
      grant_data_s = 1'b0;
      inst_valid   = 1'b0;
      inst_data    = {DATA_WIDTH{1'b0}};
      data_valid   = 1'b0;
      data_rdata   = {DATA_WIDTH{1'b0}};
      err          = 1'b0;
      case (state_r)
         IDLE: begin
            if (inst_req || data_req) begin
               grant_s = 1'b1;
               // On a tie the requester that did not win last time goes first.
               grant_data_s = data_req && (!inst_req || (last_grant_r == REQ_INST));
               state_nxt_s  = grant_data_s ? DATA_BUSY : INST_BUSY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         INST_BUSY: begin
            // A real completion beats a coinciding timeout.
            if (mem_valid) begin
               inst_valid  = 1'b1;
               inst_data   = mem_rdata;
               state_nxt_s = IDLE;
            end else if (wd_timeout_s) begin
               inst_valid  = 1'b1;
               err         = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = INST_BUSY;
            end
         end
         DATA_BUSY: begin
            if (mem_valid) begin
               data_valid  = 1'b1;
               data_rdata  = mem_rdata;
               state_nxt_s = IDLE;
            end else if (wd_timeout_s) begin
               data_valid  = 1'b1;
               err         = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DATA_BUSY;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and round-robin history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         last_grant_r <= REQ_INST;
      end else begin
         state_r <= state_nxt_s;
         if (grant_s) begin
            last_grant_r <= grant_data_s ? REQ_DATA : REQ_INST;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Outbound request fields, captured only on the grant cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_r  <= {DATA_WIDTH{1'b0}};
         wdata_r <= {DATA_WIDTH{1'b0}};
         we_r    <= 1'b0;
         be_r    <= {BYTE_DATA_WIDTH{1'b0}};
      end else if (grant_s && grant_data_s) begin
         addr_r  <= data_addr;
         wdata_r <= data_wdata;
         we_r    <= data_we;
         be_r    <= data_be;
      end else if (grant_s) begin
         addr_r  <= inst_addr;
         wdata_r <= {DATA_WIDTH{1'b0}};
         we_r    <= 1'b0;
         be_r    <= {BYTE_DATA_WIDTH{1'b1}};
      end else begin
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
         we_r    <= we_r;
         be_r    <= be_r;
      end
   end

   // mem_req follows the state register, so an asynchronous reset drops it at once.
   assign mem_req   = is_busy(state_r);
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign mem_we    = we_r;
   assign mem_be    = be_r;

endmodule
